// File: rtl/tpmem_pkg.sv
// Shared definitions for the 8x8 transpose-memory family.
// Contents: geometry constants (lanes/rows, bank count, pointer widths) and
// the lane slice helper that maps lane k of a packed vector to its bit range
// (lane 0 occupies the most significant BW bits).
package tpmem_pkg;

    localparam int unsigned N     = 8;  // lanes per vector, rows per block
    localparam int unsigned NB    = 2;  // ping-pong banks
    localparam int unsigned ROW_W = 3;  // row / lane index width
    localparam int unsigned CNT_W = 6;  // sample index within a block

    // Low bit of lane k in an N*bw vector: lane k = [(N-k)*bw-1 : (N-1-k)*bw].
    function automatic int unsigned lane_lo(input logic [ROW_W-1:0] lane,
                                            input int unsigned      bw);
        return (N - 1 - 32'(lane)) * bw;
    endfunction

endpackage

// File: rtl/tpmem_bank.sv
// One 8x8 register bank of BW-bit samples.
// Ports:
//   i_clk      clock, row write on rising edge
//   we         write enable for one full row
//   wr_row     row written when we is high
//   wr_vec     row contents, lane 0 in the most significant BW bits
//   rd_row     row of the sample being read
//   rd_lane    lane of the sample being read
//   rd_sample  combinational read of [rd_row][rd_lane]
// Contents are not reset; the owner only reads a bank once it is full.
module tpmem_bank
    import tpmem_pkg::*;
#(
    parameter int unsigned BW = 10
) (
    input  logic             i_clk,
    input  logic             we,
    input  logic [ROW_W-1:0] wr_row,
    input  logic [N*BW-1:0]  wr_vec,
    input  logic [ROW_W-1:0] rd_row,
    input  logic [ROW_W-1:0] rd_lane,
    output logic [BW-1:0]    rd_sample
);

    logic [N*BW-1:0] mem [N];
    logic [N*BW-1:0] row_vec;

    always_ff @(posedge i_clk) begin
        if (we) begin
            mem[wr_row] <= wr_vec;
        end
    end

    always_comb begin
        row_vec   = mem[rd_row];
        rd_sample = row_vec[lane_lo(rd_lane, BW) +: BW];
    end

endmodule

// File: rtl/tpmem_block_serializer.sv
// Output-end companion to the 8x8 transpose memory. Captures 8 parallel
// vectors of a transposed block into one of two ping-pong banks and drains
// each full bank as a raster-ordered serial stream with valid/ready.
// Ports:
//   i_clk       clock, all state on rising edge
//   i_Reset     asynchronous active-low reset
//   i_data      one vector, lane 0 = [8*BW-1:7*BW], lane 7 = [BW-1:0]
//   i_en        i_data valid this cycle (source cannot be stalled)
//   o_in_rdy    write bank free; i_en only accepted while high
//   o_data      serial sample
//   o_valid     o_data valid
//   i_ready     downstream accepts o_data
//   o_first     o_data is sample 0 of a block
//   o_last      o_data is sample 63 of a block
//   o_overflow  sticky: a vector arrived while o_in_rdy was low
module tpmem_block_serializer
    import tpmem_pkg::*;
#(
    parameter int unsigned BW = 10
) (
    input  logic            i_clk,
    input  logic            i_Reset,
    input  logic [8*BW-1:0] i_data,
    input  logic            i_en,
    output logic            o_in_rdy,
    output logic [BW-1:0]   o_data,
    output logic            o_valid,
    input  logic            i_ready,
    output logic            o_first,
    output logic            o_last,
    output logic            o_overflow
);

    logic [NB-1:0]    full;
    logic [NB-1:0]    full_nxt;
    logic             wr_bank;
    logic             rd_bank;
    logic [ROW_W-1:0] wr_row;
    logic [CNT_W-1:0] rd_cnt;

    logic             wr_acc;
    logic             load;
    logic             wr_done;
    logic             rd_done;
    logic [NB-1:0]    bank_we;
    logic [BW-1:0]    bank_sample [NB];
    logic [BW-1:0]    rd_sample;

    assign o_in_rdy = ~full[wr_bank];
    assign wr_acc   = i_en & o_in_rdy;
    assign load     = full[rd_bank] & (~o_valid | i_ready);
    assign wr_done  = wr_acc & (wr_row == '1);
    assign rd_done  = load & (rd_cnt == '1);
    assign bank_we  = wr_acc ? (NB'(1) << wr_bank) : '0;

    for (genvar b = 0; b < NB; b++) begin : g_bank
        tpmem_bank #(
            .BW (BW)
        ) u_bank (
            .i_clk     (i_clk),
            .we        (bank_we[b]),
            .wr_row    (wr_row),
            .wr_vec    (i_data),
            .rd_row    (rd_cnt[CNT_W-1:ROW_W]),
            .rd_lane   (rd_cnt[ROW_W-1:0]),
            .rd_sample (bank_sample[b])
        );
    end

    assign rd_sample = bank_sample[rd_bank];

    // A set and a clear can land on the same edge only for different banks:
    // setting needs full[wr_bank]=0, clearing needs full[rd_bank]=1.
    always_comb begin
        full_nxt = full;
        if (rd_done) begin
            full_nxt[rd_bank] = 1'b0;
        end
        if (wr_done) begin
            full_nxt[wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_Reset) begin
        if (!i_Reset) begin
            full       <= '0;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            wr_row     <= '0;
            rd_cnt     <= '0;
            o_data     <= '0;
            o_valid    <= 1'b0;
            o_first    <= 1'b0;
            o_last     <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            full <= full_nxt;

            if (wr_acc) begin
                wr_row <= wr_row + 1'b1;
                if (wr_done) begin
                    wr_bank <= ~wr_bank;
                end
            end

            if (i_en && !o_in_rdy) begin
                o_overflow <= 1'b1;
            end

            if (load) begin
                o_data  <= rd_sample;
                o_valid <= 1'b1;
                o_first <= (rd_cnt == '0);
                o_last  <= (rd_cnt == '1);
                rd_cnt  <= rd_cnt + 1'b1;
                if (rd_done) begin
                    rd_bank <= ~rd_bank;
                end
            end else if (o_valid && i_ready) begin
                // o_data keeps its last value once the handshake empties the register
                o_valid <= 1'b0;
                o_first <= 1'b0;
                o_last  <= 1'b0;
            end
        end
    end

endmodule
